// File: rtl/ppb_pkg.sv
// Shared constants for the ping-pong buffer bank controller.
package ppb_pkg;

   localparam logic BANK_A = 1'b0;
   localparam logic BANK_B = 1'b1;

   localparam int unsigned ERR_W   = 3;
   localparam int unsigned ERR_OVF = 0;
   localparam int unsigned ERR_UNF = 1;
   localparam int unsigned ERR_DSW = 2;

endpackage

// File: rtl/ppb_slot.sv
// One PE's ping-pong bank state: bank select, full flags, pending switch.
module ppb_slot
   import ppb_pkg::*;
(
   input  logic clk,
   input  logic rst_n,
   input  logic clear,
   input  logic fill_done,
   input  logic switch_req,
   input  logic drain_done,
   output logic wr_sel,
   output logic wr_ready,
   output logic rd_valid,
   output logic sw_pending,
   output logic rd_full_nxt_c,
   output logic pend_nxt_c,
   output logic err_ovf_c,
   output logic err_unf_c,
   output logic err_dsw_c
);

   logic wr_full;
   logic wf_c;
   logic re_c;
   logic sw_c;
   logic wr_sel_nxt_c;
   logic wr_ready_nxt_c;

   assign wr_full = ~wr_ready;

   // Protocol violations; the state update below treats them as legal events.
   assign err_ovf_c = fill_done & wr_full;
   assign err_unf_c = drain_done & ~rd_valid;
   assign err_dsw_c = switch_req & sw_pending;

   // Next-state: a swap needs a filled write bank and a drained read bank.
   always_comb begin
      wf_c           = wr_full | fill_done;
      re_c           = ~rd_valid | drain_done;
      sw_c           = (switch_req | sw_pending) & wf_c & re_c;
      wr_sel_nxt_c   = wr_sel;
      wr_ready_nxt_c = wr_ready;
      rd_full_nxt_c  = rd_valid;
      pend_nxt_c     = sw_pending;
      if (clear) begin
         wr_sel_nxt_c   = BANK_A;
         wr_ready_nxt_c = 1'b1;
         rd_full_nxt_c  = 1'b0;
         pend_nxt_c     = 1'b0;
      end else if (sw_c) begin
         wr_sel_nxt_c   = ~wr_sel;
         wr_ready_nxt_c = 1'b1;
         rd_full_nxt_c  = 1'b1;
         pend_nxt_c     = 1'b0;
      end else begin
         if (fill_done)  wr_ready_nxt_c = 1'b0;
         if (drain_done) rd_full_nxt_c  = 1'b0;
         if (switch_req) pend_nxt_c     = 1'b1;
      end
   end

   // State register; reset discards any pending switch.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_sel     <= BANK_A;
         wr_ready   <= 1'b1;
         rd_valid   <= 1'b0;
         sw_pending <= 1'b0;
      end else begin
         wr_sel     <= wr_sel_nxt_c;
         wr_ready   <= wr_ready_nxt_c;
         rd_valid   <= rd_full_nxt_c;
         sw_pending <= pend_nxt_c;
      end
   end

endmodule

// File: rtl/pingpong_buf_ctrl.sv
// Per-PE ping-pong buffer bank controller with sticky protocol errors and
// global idle flag. Optional stall counter enabled by PPB_STALL_CNT_EN.
module pingpong_buf_ctrl
   import ppb_pkg::*;
#(
   parameter int unsigned PE_NUM = 32,
   parameter int unsigned CNT_W  = 32
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              clear,
   input  logic [PE_NUM-1:0] fill_done,
   input  logic [PE_NUM-1:0] switch_req,
   input  logic [PE_NUM-1:0] drain_done,
   output logic [PE_NUM-1:0] wr_sel,
   output logic [PE_NUM-1:0] wr_ready,
   output logic [PE_NUM-1:0] rd_valid,
   output logic [PE_NUM-1:0] sw_pending,
   output logic              all_idle,
   output logic [ERR_W-1:0]  err,
   output logic [CNT_W-1:0]  stall_cnt
);

   logic [PE_NUM-1:0] rd_full_nxt_c;
   logic [PE_NUM-1:0] pend_nxt_c;
   logic [PE_NUM-1:0] ovf_c;
   logic [PE_NUM-1:0] unf_c;
   logic [PE_NUM-1:0] dsw_c;
   logic [ERR_W-1:0]  err_set_c;

   // One independent slot per PE.
   for (genvar g = 0; g < PE_NUM; g++) begin : g_slot
      ppb_slot u_slot (
         .clk           (clk),
         .rst_n         (rst_n),
         .clear         (clear),
         .fill_done     (fill_done[g]),
         .switch_req    (switch_req[g]),
         .drain_done    (drain_done[g]),
         .wr_sel        (wr_sel[g]),
         .wr_ready      (wr_ready[g]),
         .rd_valid      (rd_valid[g]),
         .sw_pending    (sw_pending[g]),
         .rd_full_nxt_c (rd_full_nxt_c[g]),
         .pend_nxt_c    (pend_nxt_c[g]),
         .err_ovf_c     (ovf_c[g]),
         .err_unf_c     (unf_c[g]),
         .err_dsw_c     (dsw_c[g])
      );
   end

   // Collapse per-PE error pulses into the error vector layout.
   always_comb begin
      err_set_c          = '0;
      err_set_c[ERR_OVF] = |ovf_c;
      err_set_c[ERR_UNF] = |unf_c;
      err_set_c[ERR_DSW] = |dsw_c;
   end

   // Sticky error flags, cleared only by clear or reset.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)     err <= '0;
      else if (clear) err <= '0;
      else            err <= err | err_set_c;
   end

   // Idle flag registered from the slots' next state so it tracks the flags.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) all_idle <= 1'b1;
      else        all_idle <= ~|rd_full_nxt_c & ~|pend_nxt_c;
   end

`ifdef PPB_STALL_CNT_EN
   // Saturating count of cycles with any switch waiting.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)                                 stall_cnt <= '0;
      else if (clear)                             stall_cnt <= '0;
      else if (|sw_pending && (stall_cnt != '1))  stall_cnt <= stall_cnt + CNT_W'(1);
   end
`else
   assign stall_cnt = '0;
`endif

endmodule

// File: tb/tb_pingpong_buf_ctrl.sv
// Self-checking bench for pingpong_buf_ctrl: directed plan plus random traffic
// against a per-PE behavioural model.
module tb_pingpong_buf_ctrl;

   localparam int unsigned N = 32;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          clear;
   logic [N-1:0]  fill_done, switch_req, drain_done;
   logic [N-1:0]  wr_sel, wr_ready, rd_valid, sw_pending;
   logic          all_idle;
   logic [2:0]    err;
   logic [31:0]   stall_cnt;

   pingpong_buf_ctrl #(.PE_NUM(N), .CNT_W(32)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .clear      (clear),
      .fill_done  (fill_done),
      .switch_req (switch_req),
      .drain_done (drain_done),
      .wr_sel     (wr_sel),
      .wr_ready   (wr_ready),
      .rd_valid   (rd_valid),
      .sw_pending (sw_pending),
      .all_idle   (all_idle),
      .err        (err),
      .stall_cnt  (stall_cnt)
   );

   always #5 clk = ~clk;

   // Behavioural model: one entry per PE.
   bit          m_sel  [N];
   bit          m_wfull[N];
   bit          m_rfull[N];
   bit          m_pend [N];
   logic [2:0]  m_err;
   longint      m_stall;

   int  n_vec  = 0;
   int  n_miss = 0;
   bit  chk_en = 0;

   function automatic void chk(string nm, logic [31:0] act, logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_miss++;
         $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
      end
   endfunction

   function automatic void model_reset();
      for (int i = 0; i < N; i++) begin
         m_sel[i] = 0; m_wfull[i] = 0; m_rfull[i] = 0; m_pend[i] = 0;
      end
      m_err   = '0;
      m_stall = 0;
   endfunction

   function automatic void model_step(logic [N-1:0] f, logic [N-1:0] r, logic [N-1:0] d, logic c);
      bit any_pend;
      bit wf, re, sw;
      if (c) begin
         model_reset();
         return;
      end
      any_pend = 0;
      for (int i = 0; i < N; i++) any_pend |= m_pend[i];
      if (any_pend && m_stall < 64'hFFFF_FFFF) m_stall++;
      for (int i = 0; i < N; i++) begin
         if (f[i] && m_wfull[i])  m_err[0] = 1'b1;
         if (d[i] && !m_rfull[i]) m_err[1] = 1'b1;
         if (r[i] && m_pend[i])   m_err[2] = 1'b1;
         wf = m_wfull[i] || f[i];
         re = !m_rfull[i] || d[i];
         sw = (r[i] || m_pend[i]) && wf && re;
         if (sw) begin
            m_sel[i]   = !m_sel[i];
            m_rfull[i] = 1;
            m_wfull[i] = 0;
            m_pend[i]  = 0;
         end else begin
            if (f[i]) m_wfull[i] = 1;
            if (d[i]) m_rfull[i] = 0;
            if (r[i]) m_pend[i]  = 1;
         end
      end
   endfunction

   // Compare every DUT output with the model each cycle, away from the edge.
   always @(negedge clk) begin
      if (chk_en) begin
         logic [N-1:0] e_sel, e_rdy, e_rv, e_pnd;
         bit           idle;
         idle = 1;
         for (int i = 0; i < N; i++) begin
            e_sel[i] = m_sel[i];
            e_rdy[i] = !m_wfull[i];
            e_rv[i]  = m_rfull[i];
            e_pnd[i] = m_pend[i];
            if (m_rfull[i] || m_pend[i]) idle = 0;
         end
         chk("wr_sel",     wr_sel,     e_sel);
         chk("wr_ready",   wr_ready,   e_rdy);
         chk("rd_valid",   rd_valid,   e_rv);
         chk("sw_pending", sw_pending, e_pnd);
         chk("all_idle",   32'(all_idle), 32'(idle));
         chk("err",        32'(err),   32'(m_err));
`ifdef PPB_STALL_CNT_EN
         chk("stall_cnt",  stall_cnt,  m_stall[31:0]);
`else
         chk("stall_cnt",  stall_cnt,  32'h0);
`endif
      end
   end

   // Apply one cycle of events; returns at the following falling edge.
   task automatic cyc(input logic [N-1:0] f, input logic [N-1:0] r,
                      input logic [N-1:0] d, input logic c);
      fill_done  = f;
      switch_req = r;
      drain_done = d;
      clear      = c;
      @(posedge clk);
      model_step(f, r, d, c);
      @(negedge clk);
   endtask

   task automatic idle_cyc();
      cyc('0, '0, '0, 1'b0);
   endtask

   task automatic do_reset();
      fill_done = '0; switch_req = '0; drain_done = '0; clear = 1'b0;
      #2 rst_n = 1'b0;
      model_reset();
      @(negedge clk);
      #2 rst_n = 1'b1;
   endtask

   function automatic logic [N-1:0] bitm(int i);
      logic [N-1:0] one;
      one = 1;
      return one << i;
   endfunction

   initial begin
      logic [N-1:0] ones;
      ones = '1;
      rst_n = 1'b0;
      fill_done = '0; switch_req = '0; drain_done = '0; clear = 1'b0;
      model_reset();
      repeat (2) @(negedge clk);
      #2 rst_n = 1'b1;
      chk_en = 1;
      @(negedge clk);
      chk("rst_all_idle", 32'(all_idle), 32'h1);
      chk("rst_wr_ready", wr_ready, 32'hFFFF_FFFF);
      chk("rst_err", 32'(err), 32'h0);

      // Basic fill then switch on PE 3.
      cyc(bitm(3), '0, '0, 1'b0);
      chk("t1_wr_ready3", 32'(wr_ready[3]), 32'h0);
      cyc('0, bitm(3), '0, 1'b0);
      chk("t1_wr_sel3", 32'(wr_sel[3]), 32'h1);
      chk("t1_rd_valid3", 32'(rd_valid[3]), 32'h1);
      chk("t1_wr_ready3b", 32'(wr_ready[3]), 32'h1);
      chk("t1_all_idle", 32'(all_idle), 32'h0);

      // Switch deferred on PE 5 until its fill arrives.
      cyc('0, bitm(5), '0, 1'b0);
      chk("t2_pend5", 32'(sw_pending[5]), 32'h1);
      repeat (4) idle_cyc();
      cyc(bitm(5), '0, '0, 1'b0);
      chk("t2_pend5_done", 32'(sw_pending[5]), 32'h0);
      chk("t2_wr_sel5", 32'(wr_sel[5]), 32'h1);
`ifdef PPB_STALL_CNT_EN
      chk("t2_stall_cnt", stall_cnt, 32'd5);
`endif

      // PE 0: switch held until the read bank drains.
      cyc(bitm(0), bitm(0), '0, 1'b0);
      cyc(bitm(0), '0, '0, 1'b0);
      cyc('0, bitm(0), '0, 1'b0);
      chk("t3_pend0", 32'(sw_pending[0]), 32'h1);
      idle_cyc();
      chk("t3_pend0_held", 32'(sw_pending[0]), 32'h1);
      cyc('0, '0, bitm(0), 1'b0);
      chk("t3_rd_valid0", 32'(rd_valid[0]), 32'h1);
      chk("t3_pend0_done", 32'(sw_pending[0]), 32'h0);
      chk("t3_wr_sel0", 32'(wr_sel[0]), 32'h0);

      // Overflow, underflow, then clear.
      cyc(bitm(7), '0, '0, 1'b0);
      cyc(bitm(7), '0, '0, 1'b0);
      chk("t4_err_ovf", 32'(err), 32'h1);
      cyc('0, '0, bitm(8), 1'b0);
      chk("t4_err_unf", 32'(err), 32'h3);
      cyc('0, '0, '0, 1'b1);
      chk("t4_err_clr", 32'(err), 32'h0);
      chk("t4_idle_clr", 32'(all_idle), 32'h1);

      // Double switch request merges into one swap.
      cyc('0, bitm(2), '0, 1'b0);
      cyc('0, bitm(2), '0, 1'b0);
      chk("t5_err_dsw", 32'(err), 32'h4);
      cyc(bitm(2), '0, '0, 1'b0);
      chk("t5_wr_sel2", 32'(wr_sel[2]), 32'h1);
      chk("t5_pend2", 32'(sw_pending[2]), 32'h0);
      repeat (2) idle_cyc();
      chk("t5_wr_sel2_stable", 32'(wr_sel[2]), 32'h1);

      // All PEs swap together, then drain together.
      cyc('0, '0, '0, 1'b1);
      cyc(ones, ones, '0, 1'b0);
      chk("t6_rd_valid_all", rd_valid, 32'hFFFF_FFFF);
      chk("t6_wr_sel_all", wr_sel, 32'hFFFF_FFFF);
      cyc('0, '0, ones, 1'b0);
      chk("t6_all_idle", 32'(all_idle), 32'h1);

      // Random traffic, with occasional clear and one mid-run reset.
      for (int k = 0; k < 3000; k++) begin
         logic [N-1:0] f, r, d;
         logic         c;
         if (k == 1500) do_reset();
         f = $urandom & $urandom;
         r = $urandom & $urandom & $urandom;
         d = $urandom & $urandom;
         c = ($urandom_range(0, 99) == 0);
         cyc(f, r, d, c);
      end
      idle_cyc();
      chk_en = 0;

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

endmodule

// File: doc/pingpong_buf_ctrl.md
# pingpong_buf_ctrl

Per-PE ping-pong buffer bank controller sitting between the instruction control, the DDR-to-PE loader and the PE array. It tracks which bank of every PE buffer the loader writes and which the PE reads. It holds full/empty state per bank and executes switch requests only when the swap is safe, deferring them otherwise. It flags protocol violations and reports global idleness for layer-boundary synchronisation.

## Interface
- PE_NUM, 32, number of PEs; one ping-pong buffer pair per PE
- CNT_W, 32, width of the optional stall counter
- clk  input  1  clock; all logic rising-edge
- rst_n  input  1  reset; asynchronous, active-low
- clear  input  1  synchronous clear of all bank state (layer reconfiguration)
- fill_done  input  PE_NUM  one-cycle pulse per PE: loader finished writing that PE's write bank
- switch_req  input  PE_NUM  one-cycle pulse per PE: swap banks (driven by the switch_d outputs of the instruction control)
- drain_done  input  PE_NUM  one-cycle pulse per PE: PE finished consuming its read bank
- wr_sel  output  PE_NUM  bank index the loader writes (0=A, 1=B); read bank is ~wr_sel
- wr_ready  output  PE_NUM  write bank empty, loader may fill
- rd_valid  output  PE_NUM  read bank full, PE may compute
- sw_pending  output  PE_NUM  switch accepted but not yet executed
- all_idle  output  1  no read bank full, no switch pending, on all PEs
- err  output  3  sticky: [0] overflow, [1] underflow, [2] double switch
- stall_cnt  output  CNT_W  cycles with any sw_pending set (only with PPB_STALL_CNT_EN)

## Operation
- Per PE state: wr_sel, wr_full, rd_full, pend. Each PE is independent; there is no cross-PE arbitration.
- Effective flags this cycle: wf = wr_full | fill_done, re = !rd_full | drain_done.
- Switch condition: sw = (switch_req | pend) & wf & re.
- On sw:
  - wr_sel toggles.
  - rd_full <= 1 (the former write bank becomes the read bank).
  - wr_full <= 0.
  - pend <= 0.
- On switch_req without sw: pend <= 1. The switch then executes in the first later cycle the condition holds.
- Without sw, each flag updates on its own: fill_done sets wr_full; drain_done clears rd_full.
- Error conditions, all sticky; state is otherwise updated as if the event were legal:
  - fill_done while wr_full=1 sets err[0].
  - drain_done while rd_full=0 sets err[1].
  - switch_req while pend=1 sets err[2]; the request merges into the existing pending one.
- Output derivation:
  - wr_ready = !wr_full.
  - rd_valid = rd_full.
  - sw_pending = pend.
  - all_idle = ~|rd_full & ~|pend.
- clear:
  - Forces every PE to wr_sel=0, with all flags and pend at 0.
  - Clears err and stall_cnt.
  - Takes priority over same-cycle events.

## Timing
- All outputs are registered.
- An event in cycle N is visible on the outputs in cycle N+1.
- The fastest complete swap is a fill_done and switch_req in the same cycle with the read bank empty: wr_sel toggles and rd_valid=1 in cycle N+1.
- Reset values (asynchronous, on rst_n=0):
  - wr_sel=0, wr_ready=all ones, rd_valid=0, sw_pending=0.
  - all_idle=1, err=0, stall_cnt=0.
- Reset mid-swap discards pending switches; no error is raised.
- drain_done and switch_req in the same cycle with a full write bank swap immediately. The old read bank is considered drained.
- stall_cnt saturates at all ones; it does not wrap.

## Configuration
- PPB_STALL_CNT_EN defined: stall_cnt increments every cycle in which |pend, and clears on clear.
- PPB_STALL_CNT_EN undefined: no counter logic is built and stall_cnt is tied to 0.

## Structure
- Shared package ppb_pkg holds:
  - bank constants BANK_A=1'b0 and BANK_B=1'b1;
  - error bit indices ERR_OVF=0, ERR_UNF=1, ERR_DSW=2.
- Sub-module ppb_slot:
  - Holds the state and switch logic of one PE and emits per-PE error pulses.
  - The top instantiates PE_NUM copies in a generate loop.
  - The top ORs the error pulses into err, and computes all_idle and stall_cnt.

## Test plan
- Reset release, then fill_done[3] -> cycle+1: wr_ready[3]=0. Then switch_req[3] -> cycle+1: wr_sel[3]=1, rd_valid[3]=1, wr_ready[3]=1, all_idle=0.
- switch_req[5] with the write bank empty -> sw_pending[5]=1. fill_done[5] 4 cycles later -> next cycle swap executes, sw_pending[5]=0. With the macro, stall_cnt=5.
- With rd_full=1, fill_done then switch_req on PE 0 -> the switch stays pending until drain_done[0]. drain_done[0] -> next cycle swap, rd_valid[0] stays 1.
- Two fill_done[7] pulses without a switch -> err=3'b001. drain_done[8] on an empty read bank -> err=3'b011. Then clear -> err=0, all_idle=1.
- Second switch_req[2] while pending -> err[2]=1 and only a single swap occurs once fill_done[2] arrives.
- All 32 PEs fill+switch in the same cycle -> rd_valid=32'hFFFF_FFFF. All 32 drain_done pulse together -> all_idle=1 next cycle.
